// File: rtl/mc_scoreboard_hazard_unit_if.sv
// Decode/writeback-side bundle for the multi-cycle scoreboard hazard unit.
// master = pipeline (decode + writeback), slave = scoreboard.
interface mc_scoreboard_hazard_unit_if #(
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = 5,
  parameter int NUM_MC     = 2,
  parameter int MC_IDX_W   = 1
);
  logic                  d_valid;
  logic [REG_ADDR_W-1:0] d_rs1;
  logic                  d_rs1_used;
  logic [REG_ADDR_W-1:0] d_rs2;
  logic                  d_rs2_used;
  logic [REG_ADDR_W-1:0] d_rd;
  logic                  d_rd_write;
  logic                  d_mc;
  logic [MC_IDX_W-1:0]   d_mc_idx;
  logic                  flush;
  logic [NUM_MC-1:0]     cpl_valid;
  logic                  stall;
  logic                  issue;
  logic [NUM_REGS-1:0]   busy_vec;
  logic [NUM_MC-1:0]     unit_busy;
  logic [31:0]           stall_cnt;

  modport master (
    output d_valid, d_rs1, d_rs1_used, d_rs2, d_rs2_used, d_rd, d_rd_write,
           d_mc, d_mc_idx, flush, cpl_valid,
    input  stall, issue, busy_vec, unit_busy, stall_cnt
  );

  modport slave (
    input  d_valid, d_rs1, d_rs1_used, d_rs2, d_rs2_used, d_rd, d_rd_write,
           d_mc, d_mc_idx, flush, cpl_valid,
    output stall, issue, busy_vec, unit_busy, stall_cnt
  );
endinterface

// File: rtl/mc_scoreboard_hazard_unit.sv
// Scoreboard hazard unit: tracks pending writes of multi-cycle units and stalls decode on RAW/WAW/structural hazards.
// Optional stall-cycle counter enabled by defining HAZ_PERF_CNT_EN.
//
//  state  | meaning
//  S_IDLE | unit free, no destination tracked
//  S_BUSY | unit occupied, r_unit_rd holds its pending destination (0 if it writes nothing)
module mc_scoreboard_hazard_unit #(
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = 5,
  parameter int NUM_MC     = 2,
  parameter int MC_IDX_W   = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  mc_scoreboard_hazard_unit_if.slave bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;
  localparam logic [NUM_REGS-1:0] REG0_MASK = {{(NUM_REGS-1){1'b1}}, 1'b0};

  logic [0:0]            r_state   [NUM_MC];
  logic [REG_ADDR_W-1:0] r_unit_rd [NUM_MC];
  logic [NUM_REGS-1:0]   r_busy_vec;

  logic [NUM_MC-1:0]     w_unit_busy;
  logic [NUM_MC-1:0]     w_unit_issue;
  logic [NUM_REGS-1:0]   w_clr_vec;
  logic [NUM_REGS-1:0]   w_set_vec;
  logic [NUM_REGS-1:0]   w_pend;
  logic [REG_ADDR_W-1:0] w_rd_tracked;
  logic                  w_idx_ok;
  logic                  w_raw;
  logic                  w_waw;
  logic                  w_struc;
  logic                  w_stall;
  logic                  w_issue;

  // Writeback bypass: a register completing this cycle is no longer pending.
  always_comb begin
    w_clr_vec = '0;
    for (int i = 0; i < NUM_MC; i++) begin
      w_unit_busy[i] = (r_state[i] == S_BUSY);
      if (w_unit_busy[i] && bus.cpl_valid[i])
        w_clr_vec[r_unit_rd[i]] = 1'b1;
    end
  end

  assign w_pend = r_busy_vec & ~w_clr_vec & REG0_MASK;

  always_comb begin
    w_idx_ok = 1'b0;
    w_struc  = 1'b0;
    for (int i = 0; i < NUM_MC; i++) begin
      if (bus.d_mc_idx == MC_IDX_W'(i)) begin
        w_idx_ok = 1'b1;
        w_struc  = w_unit_busy[i] & ~bus.cpl_valid[i];
      end
    end
    // An out-of-range unit index never frees up, so it stalls forever.
    w_struc = bus.d_mc & (w_struc | ~w_idx_ok);
  end

  assign w_raw   = (bus.d_rs1_used & w_pend[bus.d_rs1]) | (bus.d_rs2_used & w_pend[bus.d_rs2]);
  assign w_waw   = bus.d_rd_write & (bus.d_rd != '0) & w_pend[bus.d_rd];
  assign w_stall = ~i_rst & bus.d_valid & ~bus.flush & (w_raw | w_waw | w_struc);
  assign w_issue = ~i_rst & bus.d_valid & ~bus.flush & ~w_stall;

  // Units that write nothing track reg 0 so their completion cannot clear another unit's bit.
  assign w_rd_tracked = bus.d_rd_write ? bus.d_rd : '0;

  always_comb begin
    w_set_vec = '0;
    for (int i = 0; i < NUM_MC; i++)
      w_unit_issue[i] = w_issue & bus.d_mc & (bus.d_mc_idx == MC_IDX_W'(i));
    if (w_issue && bus.d_mc && w_idx_ok && bus.d_rd_write && (bus.d_rd != '0))
      w_set_vec[bus.d_rd] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy_vec <= '0;
      for (int i = 0; i < NUM_MC; i++) begin
        r_state[i]   <= S_IDLE;
        r_unit_rd[i] <= '0;
      end
    end else begin
      r_busy_vec <= (r_busy_vec & ~w_clr_vec) | w_set_vec;
      for (int i = 0; i < NUM_MC; i++) begin
        case (r_state[i])
          S_IDLE: begin
            if (w_unit_issue[i]) begin
              r_state[i]   <= S_BUSY;
              r_unit_rd[i] <= w_rd_tracked;
            end
          end
          S_BUSY: begin
            if (w_unit_issue[i])
              r_unit_rd[i] <= w_rd_tracked;
            else if (bus.cpl_valid[i])
              r_state[i] <= S_IDLE;
          end
        endcase
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_stall_cnt <= 32'd0;
    else if (w_stall)
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign bus.stall_cnt = r_stall_cnt;
`else
  assign bus.stall_cnt = 32'd0;
`endif

  assign bus.stall     = w_stall;
  assign bus.issue     = w_issue;
  assign bus.busy_vec  = r_busy_vec;
  assign bus.unit_busy = w_unit_busy;

  a_mc_idx_legal: assert property (@(posedge i_clk) disable iff (i_rst)
    (bus.d_valid && bus.d_mc) |-> w_idx_ok);

endmodule

// File: tb/tb_mc_scoreboard_hazard_unit.sv
// Directed table-driven bench for mc_scoreboard_hazard_unit plus a multi-cycle stall-count sequence.
module tb_mc_scoreboard_hazard_unit;

  typedef struct {
    logic        rst;
    logic        valid;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [4:0]  rd;
    logic        wr;
    logic        mc;
    logic        idx;
    logic        flush;
    logic [1:0]  cpl;
    logic        e_stall;
    logic        e_issue;
    logic [31:0] e_busy;
    logic [1:0]  e_ub;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_cnt = 32'd0;
  vec_t vecs [36];

  always #5 clk = ~clk;

  mc_scoreboard_hazard_unit_if #(.NUM_REGS(32), .REG_ADDR_W(5), .NUM_MC(2), .MC_IDX_W(1)) bus ();

  mc_scoreboard_hazard_unit #(.NUM_REGS(32), .REG_ADDR_W(5), .NUM_MC(2), .MC_IDX_W(1)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  function automatic vec_t mk(input logic r, input logic v,
                              input logic [4:0] s1, input logic s1u,
                              input logic [4:0] s2, input logic s2u,
                              input logic [4:0] d, input logic w, input logic m, input logic ix,
                              input logic f, input logic [1:0] c,
                              input logic es, input logic ei, input logic [31:0] eb, input logic [1:0] eu);
    vec_t t;
    t.rst = r; t.valid = v; t.rs1 = s1; t.u1 = s1u; t.rs2 = s2; t.u2 = s2u;
    t.rd = d; t.wr = w; t.mc = m; t.idx = ix; t.flush = f; t.cpl = c;
    t.e_stall = es; t.e_issue = ei; t.e_busy = eb; t.e_ub = eu;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt_sel();
`ifdef HAZ_PERF_CNT_EN
    return exp_cnt;
`else
    return 32'd0;
`endif
  endfunction

  task automatic drive(input vec_t v);
    rst              = v.rst;
    bus.d_valid      = v.valid;
    bus.d_rs1        = v.rs1;
    bus.d_rs1_used   = v.u1;
    bus.d_rs2        = v.rs2;
    bus.d_rs2_used   = v.u2;
    bus.d_rd         = v.rd;
    bus.d_rd_write   = v.wr;
    bus.d_mc         = v.mc;
    bus.d_mc_idx     = v.idx;
    bus.flush        = v.flush;
    bus.cpl_valid    = v.cpl;
  endtask

  // Apply at negedge, compare 1 ns later, then step the stall-count model across the posedge.
  task automatic step(input vec_t v, input string tag);
    drive(v);
    #1;
    chk({tag, " stall"},     {31'd0, bus.stall},     {31'd0, v.e_stall});
    chk({tag, " issue"},     {31'd0, bus.issue},     {31'd0, v.e_issue});
    chk({tag, " busy_vec"},  bus.busy_vec,           v.e_busy);
    chk({tag, " unit_busy"}, {30'd0, bus.unit_busy}, {30'd0, v.e_ub});
    chk({tag, " stall_cnt"}, bus.stall_cnt,          exp_cnt_sel());
    @(posedge clk);
    if (v.rst) exp_cnt = 32'd0;
    else if (v.e_stall) exp_cnt = exp_cnt + 32'd1;
    @(negedge clk);
  endtask

  initial begin
    //                 rst v  rs1 u1 rs2 u2 rd w mc ix fl cpl     st is busy       ub
    // reset state
    vecs[0]  = mk(0, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0, 2'b00,  0, 0, 32'h0,     2'b00);
    // DIV x5 unit0, then ADD x6,x5,x1 waits for completion
    vecs[1]  = mk(0, 1,  1, 1,  2, 1,  5, 1, 1, 0, 0, 2'b00,  0, 1, 32'h0,     2'b00);
    vecs[2]  = mk(0, 1,  5, 1,  1, 1,  6, 1, 0, 0, 0, 2'b00,  1, 0, 32'h20,    2'b01);
    vecs[3]  = mk(0, 1,  5, 1,  1, 1,  6, 1, 0, 0, 0, 2'b00,  1, 0, 32'h20,    2'b01);
    vecs[4]  = mk(0, 1,  5, 1,  1, 1,  6, 1, 0, 0, 0, 2'b01,  0, 1, 32'h20,    2'b01);
    vecs[5]  = mk(0, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0, 2'b00,  0, 0, 32'h0,     2'b00);
    // WAW: DIV x5 unit0, LW x5 unit1 issues in the completion cycle, set wins
    vecs[6]  = mk(0, 1,  0, 0,  0, 0,  5, 1, 1, 0, 0, 2'b00,  0, 1, 32'h0,     2'b00);
    vecs[7]  = mk(0, 1,  2, 1,  0, 0,  5, 1, 1, 1, 0, 2'b00,  1, 0, 32'h20,    2'b01);
    vecs[8]  = mk(0, 1,  2, 1,  0, 0,  5, 1, 1, 1, 0, 2'b01,  0, 1, 32'h20,    2'b01);
    vecs[9]  = mk(0, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0, 2'b00,  0, 0, 32'h20,    2'b10);
    vecs[10] = mk(0, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0, 2'b10,  0, 0, 32'h20,    2'b10);
    vecs[11] = mk(0, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0, 2'b00,  0, 0, 32'h0,     2'b00);
    // structural: back-to-back DIVs on unit0, reissue in completion cycle
    vecs[12] = mk(0, 1,  0, 0,  0, 0,  7, 1, 1, 0, 0, 2'b00,  0, 1, 32'h0,     2'b00);
    vecs[13] = mk(0, 1,  1, 1,  0, 0,  8, 1, 1, 0, 0, 2'b00,  1, 0, 32'h80,    2'b01);
    vecs[14] = mk(0, 1,  1, 1,  0, 0,  8, 1, 1, 0, 0, 2'b01,  0, 1, 32'h80,    2'b01);
    vecs[15] = mk(0, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0, 2'b00,  0, 0, 32'h100,   2'b01);
    vecs[16] = mk(0, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0, 2'b01,  0, 0, 32'h100,   2'b01);
    vecs[17] = mk(0, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0, 2'b00,  0, 0, 32'h0,     2'b00);
    // DIV x0: unit busy but no register pending
    vecs[18] = mk(0, 1,  0, 0,  0, 0,  0, 1, 1, 0, 0, 2'b00,  0, 1, 32'h0,     2'b00);
    vecs[19] = mk(0, 1,  0, 1,  0, 1,  1, 1, 0, 0, 0, 2'b00,  0, 1, 32'h0,     2'b01);
    vecs[20] = mk(0, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0, 2'b00,  0, 0, 32'h0,     2'b01);
    vecs[21] = mk(0, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0, 2'b01,  0, 0, 32'h0,     2'b01);
    vecs[22] = mk(0, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0, 2'b00,  0, 0, 32'h0,     2'b00);
    // flush masks hazard; completion on idle unit ignored; reset mid-operation
    vecs[23] = mk(0, 1,  0, 0,  0, 0,  9, 1, 1, 1, 0, 2'b00,  0, 1, 32'h0,     2'b00);
    vecs[24] = mk(0, 1,  9, 1,  0, 0, 10, 1, 0, 0, 1, 2'b00,  0, 0, 32'h200,   2'b10);
    vecs[25] = mk(0, 1,  9, 1,  0, 0, 10, 1, 0, 0, 0, 2'b00,  1, 0, 32'h200,   2'b10);
    vecs[26] = mk(0, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0, 2'b01,  0, 0, 32'h200,   2'b10);
    vecs[27] = mk(0, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0, 2'b00,  0, 0, 32'h200,   2'b10);
    vecs[28] = mk(1, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0, 2'b00,  0, 0, 32'h200,   2'b10);
    vecs[29] = mk(0, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0, 2'b10,  0, 0, 32'h0,     2'b00);
    vecs[30] = mk(0, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0, 2'b00,  0, 0, 32'h0,     2'b00);
    // rs2 RAW, and an unused source does not stall
    vecs[31] = mk(0, 1,  0, 0,  0, 0,  3, 1, 1, 1, 0, 2'b00,  0, 1, 32'h0,     2'b00);
    vecs[32] = mk(0, 1,  1, 1,  3, 1, 10, 1, 0, 0, 0, 2'b00,  1, 0, 32'h8,     2'b10);
    vecs[33] = mk(0, 1,  1, 1,  3, 0, 10, 1, 0, 0, 0, 2'b00,  0, 1, 32'h8,     2'b10);
    vecs[34] = mk(0, 0,  3, 1,  0, 0,  0, 0, 0, 0, 0, 2'b10,  0, 0, 32'h8,     2'b10);
    vecs[35] = mk(0, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0, 2'b00,  0, 0, 32'h0,     2'b00);

    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 32'h0, 2'b00));
    repeat (2) @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < 36; i++)
      step(vecs[i], $sformatf("v%0d", i));

    // Long-latency DIV x4: seven stall cycles, then the dependent ADD issues on completion.
    step(mk(0, 1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 2'b00, 0, 1, 32'h0, 2'b00), "seq div");
    for (int k = 0; k < 7; k++)
      step(mk(0, 1, 4, 1, 0, 0, 11, 1, 0, 0, 0, 2'b00, 1, 0, 32'h10, 2'b01), $sformatf("seq stall%0d", k));
    step(mk(0, 1, 4, 1, 0, 0, 11, 1, 0, 0, 0, 2'b01, 0, 1, 32'h10, 2'b01), "seq cpl");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 32'h0, 2'b00), "seq done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
